// File: rtl/eth_frame_builder.sv
// eth_frame_builder: MAC header + payload + zero pad dibit serialiser for RMII tx.
// Define ETH_FRAME_BUILDER_VLAN_EN to insert an 802.1Q tag after SRC_MAC.
module eth_frame_builder #(
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC     = 48'h00_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE   = 16'h0800,
`ifdef ETH_FRAME_BUILDER_VLAN_EN
  parameter logic [15:0] VLAN_TCI    = 16'h0001,
`endif
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          GAP_CYCLES  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       busy,
  output logic       err_underrun,
  output logic       err_oversize
);

`ifdef ETH_FRAME_BUILDER_VLAN_EN
  localparam int HDR_LEN = 18;
  localparam int MIN_EFF = MIN_PAYLOAD - 4;
  localparam logic [HDR_LEN*8-1:0] HDR =
    {DST_MAC, SRC_MAC, 8'h81, 8'h00, VLAN_TCI, ETHERTYPE};
`else
  localparam int HDR_LEN = 14;
  localparam int MIN_EFF = MIN_PAYLOAD;
  localparam logic [HDR_LEN*8-1:0] HDR =
    {DST_MAC, SRC_MAC, ETHERTYPE};
`endif
  localparam logic [7:0] HDR0 = HDR[HDR_LEN*8-1 -: 8];

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_PAD, S_END, S_GAP
  } state_t;

  state_t      state;
  logic [7:0]  cur;
  logic [1:0]  dibit_cnt;
  logic [4:0]  byte_cnt;
  logic [10:0] payload_cnt;
  logic [10:0] pad_cnt;
  logic [7:0]  gap_cnt;
  logic        last_q;

  logic        last_dibit;
  logic        hdr_done;
  logic        at_max;
  logic        pad_done;
  logic [7:0]  hdr_nxt;
  int          hdr_pos;

  assign last_dibit = dibit_cnt == 2'd3;
  assign hdr_done   = byte_cnt == 5'(HDR_LEN - 1);
  assign at_max     = payload_cnt == 11'(MAX_PAYLOAD);
  assign pad_done   = (payload_cnt + pad_cnt) >= 11'(MIN_EFF);

  // Header byte following the one currently on the wire.
  always_comb begin
    hdr_pos = HDR_LEN - 2 - int'(byte_cnt);
    if (hdr_pos < 0) hdr_pos = 0;
    hdr_nxt = HDR[8*hdr_pos +: 8];
  end

  always_comb begin
    byte_ready = 1'b0;
    if (rst && last_dibit)
      unique case (1'b1)
        state == S_HEADER:  byte_ready = hdr_done;
        state == S_PAYLOAD: byte_ready = !last_q && !at_max;
        default:            byte_ready = 1'b0;
      endcase
  end

  assign err_underrun = byte_ready && !byte_valid;
  assign err_oversize = rst && last_dibit && state == S_PAYLOAD &&
                        !last_q && at_max;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cur         <= '0;
      dibit_cnt   <= '0;
      byte_cnt    <= '0;
      payload_cnt <= '0;
      pad_cnt     <= '0;
      gap_cnt     <= '0;
      last_q      <= 1'b0;
      axiov       <= 1'b0;
      axiod       <= '0;
      busy        <= 1'b0;
    end else begin
      if (state == S_HEADER || state == S_PAYLOAD || state == S_PAD) begin
        dibit_cnt <= dibit_cnt + 2'd1;
        if (!last_dibit) begin
          axiod <= cur[3:2];
          cur   <= {2'b00, cur[7:2]};
        end
      end
      unique case (state)
        S_IDLE: if (byte_valid) begin
          state       <= S_HEADER;
          axiov       <= 1'b1;
          busy        <= 1'b1;
          cur         <= HDR0;
          axiod       <= HDR0[1:0];
          dibit_cnt   <= '0;
          byte_cnt    <= '0;
          payload_cnt <= '0;
          pad_cnt     <= '0;
          last_q      <= 1'b0;
        end
        S_HEADER: if (last_dibit) begin
          if (!hdr_done) begin
            byte_cnt <= byte_cnt + 5'd1;
            cur      <= hdr_nxt;
            axiod    <= hdr_nxt[1:0];
          end else if (byte_valid) begin
            state       <= S_PAYLOAD;
            payload_cnt <= 11'd1;
            last_q      <= byte_last;
            cur         <= byte_data;
            axiod       <= byte_data[1:0];
          end else begin
            state   <= S_PAD;
            pad_cnt <= 11'd1;
            cur     <= '0;
            axiod   <= '0;
          end
        end
        S_PAYLOAD: if (last_dibit) begin
          if (!last_q && !at_max && byte_valid) begin
            payload_cnt <= payload_cnt + 11'd1;
            last_q      <= byte_last;
            cur         <= byte_data;
            axiod       <= byte_data[1:0];
          end else if (payload_cnt < 11'(MIN_EFF)) begin
            state   <= S_PAD;
            pad_cnt <= 11'd1;
            cur     <= '0;
            axiod   <= '0;
          end else begin
            state <= S_END;
            axiov <= 1'b0;
            axiod <= '0;
          end
        end
        S_PAD: if (last_dibit) begin
          if (pad_done) begin
            state <= S_END;
            axiov <= 1'b0;
            axiod <= '0;
          end else begin
            pad_cnt <= pad_cnt + 11'd1;
          end
        end
        S_END: begin
          state   <= S_GAP;
          gap_cnt <= 8'(GAP_CYCLES - 1);
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_builder.sv
// tb_eth_frame_builder: directed scenarios for eth_frame_builder.
// Captures the dibit stream of each frame and the idle run that follows.
module tb_eth_frame_builder;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;
  logic       axiov;
  logic [1:0] axiod;
  logic       busy;
  logic       err_underrun;
  logic       err_oversize;

  int tests = 0;
  int fails = 0;

  logic [1:0] q[$];
  int src_idx, src_base;
  int gap_len, gap_busy;
  int underruns, oversizes;
  int ur_pos, ov_pos;
  bit fin;

  eth_frame_builder dut (
    .clk(clk), .rst(rst),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready),
    .axiov(axiov), .axiod(axiod), .busy(busy),
    .err_underrun(err_underrun), .err_oversize(err_oversize)
  );

  always #10 clk = ~clk;

  task automatic drive_src(input int last_idx, input int drop_idx);
    byte_valid = (drop_idx < 0) || (src_idx < drop_idx);
    byte_data  = 8'(src_base + src_idx);
    byte_last  = (src_idx == last_idx);
  endtask

  // Capture one frame; with keep, also count the idle run until the next rise.
  task automatic run(input int last_idx, input int drop_idx, input bit keep);
    int phase;
    bit hs;
    q.delete();
    gap_len = 0; gap_busy = 0;
    underruns = 0; oversizes = 0;
    ur_pos = -1; ov_pos = -1;
    fin = 0; phase = 0;
    drive_src(last_idx, drop_idx);
    #1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (phase == 2 && axiov) begin fin = 1; break; end
      if (axiov) begin
        phase = 1;
        q.push_back(axiod);
      end else if (phase == 1) begin
        phase = 2;
      end
      if (err_underrun) begin underruns++; ur_pos = q.size() - 1; end
      if (err_oversize) begin oversizes++; ov_pos = q.size() - 1; end
      if (phase == 2) begin
        gap_len++;
        if (busy) gap_busy++;
        if (!keep) begin fin = 1; break; end
      end
      hs = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (hs) src_idx++;
      drive_src(last_idx, drop_idx);
      #1;
    end
    if (!keep) byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    int nz;
    rst = 1'b0; byte_valid = 1'b0;
    byte_data = '0; byte_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      if (axiov !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) nz++;
      @(posedge clk); #1;
    end
    tests++;
    if (nz !== 0) begin
      fails++; $display("FAIL reset_idle: %0d active cycles, want 0", nz);
    end
    tests++;
    if (axiod !== 2'd0) begin
      fails++; $display("FAIL reset_axiod: got %0d want 0", axiod);
    end
    tests++;
    if ({err_underrun, err_oversize} !== 2'b00) begin
      fails++; $display("FAIL reset_err: got %b want 00", {err_underrun, err_oversize});
    end
  endtask

  task automatic test_full46;
    logic [1:0] exp_q[16];
    exp_q = '{3,3,3,3, 0,2,0,0, 0,0,0,0, 1,3,2,0};
    src_idx = 0; src_base = 0;
    run(45, -1, 1'b1);
    tests++;
    if (fin !== 1'b1) begin fails++; $display("FAIL f46_timeout: got %0d want 1", fin); end
    tests++;
    if (q.size() !== 240) begin fails++; $display("FAIL f46_len: got %0d want 240", q.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (q.size() == 240 && q[k] !== exp_q[k]) begin
        fails++; $display("FAIL f46_dst d%0d: got %0d want %0d", k, q[k], exp_q[k]);
      end
      tests++;
      if (q.size() == 240 && q[48+k] !== exp_q[4+k]) begin
        fails++; $display("FAIL f46_etype d%0d: got %0d want %0d", k, q[48+k], exp_q[4+k]);
      end
      tests++;
      if (q.size() == 240 && q[56+k] !== exp_q[8+k]) begin
        fails++; $display("FAIL f46_b0 d%0d: got %0d want %0d", k, q[56+k], exp_q[8+k]);
      end
      tests++;
      if (q.size() == 240 && q[236+k] !== exp_q[12+k]) begin
        fails++; $display("FAIL f46_b45 d%0d: got %0d want %0d", k, q[236+k], exp_q[12+k]);
      end
    end
    tests++;
    if (underruns + oversizes !== 0) begin
      fails++; $display("FAIL f46_err: got %0d pulses want 0", underruns + oversizes);
    end
    tests++;
    if (gap_len !== 102) begin fails++; $display("FAIL f46_gap: got %0d want 102", gap_len); end
    tests++;
    if (gap_busy !== 101) begin fails++; $display("FAIL f46_gap_busy: got %0d want 101", gap_busy); end
  endtask

  task automatic test_mid_reset;
    src_idx = 0; src_base = 8'hA5;
    drive_src(0, -1);
    repeat (20) begin @(posedge clk); #1; end
    tests++;
    if (axiov !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL mr_pre: got v=%b b=%b want 1 1", axiov, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (axiov !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL mr_abort: got v=%b b=%b want 0 0", axiov, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (axiov !== 1'b1 || axiod !== 2'd3) begin
      fails++; $display("FAIL mr_restart: got v=%b d=%0d want 1 3", axiov, axiod);
    end
  endtask

  task automatic test_pad;
    int nz;
    logic [1:0] exp_q[4];
    exp_q = '{1,1,2,2};
    run(0, -1, 1'b0);
    tests++;
    if (q.size() !== 240) begin fails++; $display("FAIL pad_len: got %0d want 240", q.size()); end
    tests++;
    if (q.size() == 240 && q[0] !== 2'd3) begin fails++; $display("FAIL pad_first: got %0d want 3", q[0]); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (q.size() == 240 && q[56+k] !== exp_q[k]) begin
        fails++; $display("FAIL pad_a5 d%0d: got %0d want %0d", k, q[56+k], exp_q[k]);
      end
    end
    nz = 0;
    for (int k = 60; k < q.size(); k++) if (q[k] !== 2'd0) nz++;
    tests++;
    if (nz !== 0) begin fails++; $display("FAIL pad_zero: got %0d nonzero want 0", nz); end
    tests++;
    if (src_idx !== 1) begin fails++; $display("FAIL pad_consumed: got %0d want 1", src_idx); end
  endtask

  task automatic test_underrun;
    int nz;
    logic [1:0] exp_q[4];
    exp_q = '{1,2,0,0};
    src_idx = 0; src_base = 0;
    run(-1, 10, 1'b0);
    tests++;
    if (fin !== 1'b1) begin fails++; $display("FAIL ur_timeout: got %0d want 1", fin); end
    tests++;
    if (q.size() !== 240) begin fails++; $display("FAIL ur_len: got %0d want 240", q.size()); end
    tests++;
    if (underruns !== 1) begin fails++; $display("FAIL ur_count: got %0d want 1", underruns); end
    tests++;
    if (ur_pos !== 95) begin fails++; $display("FAIL ur_pos: got %0d want 95", ur_pos); end
    tests++;
    if (oversizes !== 0) begin fails++; $display("FAIL ur_ovs: got %0d want 0", oversizes); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (q.size() == 240 && q[92+k] !== exp_q[k]) begin
        fails++; $display("FAIL ur_b9 d%0d: got %0d want %0d", k, q[92+k], exp_q[k]);
      end
    end
    nz = 0;
    for (int k = 96; k < q.size(); k++) if (q[k] !== 2'd0) nz++;
    tests++;
    if (nz !== 0) begin fails++; $display("FAIL ur_pad: got %0d nonzero want 0", nz); end
  endtask

  task automatic test_oversize;
    logic [1:0] exp_q[4];
    exp_q = '{0,3,1,3};
    src_idx = 0; src_base = 0;
    run(-1, -1, 1'b1);
    tests++;
    if (fin !== 1'b1) begin fails++; $display("FAIL ov_timeout: got %0d want 1", fin); end
    tests++;
    if (q.size() !== 6056) begin fails++; $display("FAIL ov_len: got %0d want 6056", q.size()); end
    tests++;
    if (oversizes !== 1) begin fails++; $display("FAIL ov_count: got %0d want 1", oversizes); end
    tests++;
    if (ov_pos !== 6055) begin fails++; $display("FAIL ov_pos: got %0d want 6055", ov_pos); end
    tests++;
    if (underruns !== 0) begin fails++; $display("FAIL ov_ur: got %0d want 0", underruns); end
    tests++;
    if (gap_len !== 102) begin fails++; $display("FAIL ov_gap: got %0d want 102", gap_len); end
    tests++;
    if (src_idx !== 1500) begin fails++; $display("FAIL ov_consumed: got %0d want 1500", src_idx); end
    run(1500, -1, 1'b0);
    tests++;
    if (q.size() !== 240) begin fails++; $display("FAIL ov_next_len: got %0d want 240", q.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (q.size() == 240 && q[56+k] !== exp_q[k]) begin
        fails++; $display("FAIL ov_next_b0 d%0d: got %0d want %0d", k, q[56+k], exp_q[k]);
      end
    end
    tests++;
    if (src_idx !== 1501) begin fails++; $display("FAIL ov_next_consumed: got %0d want 1501", src_idx); end
  endtask

  initial begin
    test_reset();
    test_full46();
    test_mid_reset();
    test_pad();
    test_underrun();
    test_oversize();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_frame_builder.md
Name: eth_frame_builder

Overview:
- Upstream neighbour of the RMII transmit stage that adds preamble, SFD and FCS.
- Takes a payload byte stream from the packet source and emits a gap-free 2-bit dibit stream on axiov/axiod. The stream consists of destination MAC, source MAC, EtherType, payload, then zero padding to the 46-byte minimum.
- Enforces an inter-frame hold-off so the downstream stage drains its preamble skew and FCS before the next frame starts.

Parameters:
- DST_MAC, 48'hFF_FF_FF_FF_FF_FF, destination MAC address.
- SRC_MAC, 48'h00_00_00_00_00_01, source MAC address.
- ETHERTYPE, 16'h0800, EtherType field.
- MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded up to this.
- MAX_PAYLOAD, 1500, payload bytes after which the frame is forcibly ended.
- GAP_CYCLES, 100, idle clocks after axiov falls before the next frame may start. Covers 32-cycle downstream skew + 16-cycle FCS + 48-cycle IPG + margin.

Ports:
- clk  input  1  50 MHz clock
- rst  input  1  synchronous reset, active-low (asserted when 0)
- byte_valid  input  1  payload byte available
- byte_data  input  8  payload byte
- byte_last  input  1  marks final payload byte of frame
- byte_ready  output  1  byte consumed this cycle when byte_valid also high
- axiov  output  1  dibit stream valid, to transmit stage
- axiod  output  2  dibit data, to transmit stage
- busy  output  1  high from frame start through end of GAP
- err_underrun  output  1  one-cycle pulse: byte_valid low at a required fetch
- err_oversize  output  1  one-cycle pulse: MAX_PAYLOAD reached without byte_last

Behaviour:
- Reset (rst==0 at posedge): state IDLE; axiov=0, axiod=0, byte_ready=0, busy=0, err pulses=0; all counters cleared. Reset mid-frame aborts immediately: axiov is 0 on the next cycle and no gap is enforced.
- Byte serialisation: bytes go out in order. Each byte takes 4 cycles, LSB dibit first: [1:0], [3:2], [5:4], [7:6].
  - MACs go out MS byte first; DST_MAC[47:40] is the first byte on the wire.
  - EtherType goes out high byte first.
- axiov is contiguous for the whole frame: no bubbles between header, payload and pad.
- States:
  - IDLE: byte_ready=0. When byte_valid=1, the frame starts without consuming the byte; next cycle state=HEADER, axiov=1, busy=1, axiod=DST_MAC[41:40].
  - HEADER: 14 bytes = 56 cycles.
    - On the last dibit of header byte 13, byte_ready=1 (combinational) to fetch payload byte 0.
    - Fetch succeeds -> PAYLOAD.
    - byte_valid=0 -> err_underrun pulse, go to PAD.
  - PAYLOAD: on the 4th dibit of each byte, byte_ready=1 unless the current byte had byte_last=1 or payload_cnt==MAX_PAYLOAD. Transitions at end of the current byte:
    - byte_last seen: to PAD if payload_cnt<MIN_PAYLOAD, else END.
    - Fetch misses (byte_valid=0): err_underrun pulse, then treat as byte_last.
    - payload_cnt reaches MAX_PAYLOAD without byte_last: err_oversize pulse, then END. Remaining upstream bytes are left unconsumed and start the next frame.
  - PAD: emits dibit 2'b00 until payload_cnt+pad_cnt==MIN_PAYLOAD bytes, then END.
  - END: single transition cycle. axiov=0, axiod=0, gap counter loaded.
  - GAP: axiov=0 for GAP_CYCLES cycles, byte_ready=0, busy=1, then IDLE with busy=0.
- Latency: byte_valid rising in IDLE gives axiov=1 exactly one cycle later.
- Frame length:
  - Minimum frame = 60 bytes = 240 axiov cycles.
  - Maximum frame = 14+MAX_PAYLOAD bytes.
- Widths: payload_cnt is 11 bits (saturates at MAX_PAYLOAD); dibit_cnt is 2 bits, wrapping 3->0; gap counter is 8 bits.
- Simultaneous events:
  - byte_last on a byte that also hits MAX_PAYLOAD counts as a normal end; no err_oversize.
  - Underrun and the MIN_PAYLOAD shortfall: pad as normal.

Optional Feature:
- Macro ETH_FRAME_BUILDER_VLAN_EN.
- When defined:
  - Parameter VLAN_TCI (default 16'h0001) is added.
  - A 4-byte 802.1Q tag (8'h81, 8'h00, TCI[15:8], TCI[7:0]) is inserted between SRC_MAC and EtherType, making HEADER 18 bytes = 72 cycles.
  - Effective pad minimum becomes MIN_PAYLOAD-4 (42 by default).
- When undefined: 14-byte header, no TCI parameter.

Test Plan:
- rst=0 for 3 cycles, then rst=1 with byte_valid=0 -> axiov=0, busy=0, byte_ready=0 indefinitely.
- 46-byte payload 8'h00..8'h2D, byte_last on byte 45, upstream always valid:
  - axiov high for exactly 240 contiguous cycles.
  - First 4 dibits = 3,3,3,3 (DST 8'hFF).
  - Payload byte 8'h2D serialises as 1,3,2,0.
  - No padding.
  - axiov low for 100 cycles before the next frame may start.
- 1-byte payload 8'hA5 with byte_last -> dibits 1,1,2,2 follow EtherType, then 180 cycles of 2'b00 pad; total 240 cycles.
- Upstream drops byte_valid after payload byte 9 -> one err_underrun pulse on the fetch cycle, pad to 46 bytes, axiov stays contiguous.
- Payload stream never asserts byte_last -> err_oversize after byte 1499, axiov falls after 1514*4 cycles; after the gap the next frame starts with byte 1500.
- rst=0 at header cycle 20 -> axiov=0 next cycle; with byte_valid=1 after release, the new frame starts one cycle after rst returns to 1 with no gap.
